// File: rtl/puf_soc_pkg.sv
// Shared types and constants for the PUF SoC serial response path.
// The TX FSM state encoding lives here so the top and any debug logic agree on it.
package puf_soc_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } tx_state_e;

    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_BYTE_W     = 8;

    // Cycles needed to send a burst of bytes, from first start-bit cycle to the done pulse.
    function automatic int unsigned frame_cycles(input int unsigned num_bytes,
                                                 input int unsigned clks_per_bit);
        return num_bytes * UART_FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/puf_soc_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the terminal count; i_clear holds it at zero.
module puf_soc_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == TERM_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = w_term && !i_clear;

endmodule

// File: rtl/puf_soc_uart_tx.sv
// 8N1 UART transmitter for the PUF response word: sends DATA_WIDTH/8 bytes LSB-byte first
// on a rising edge of i_tx_enable and returns a one-cycle done pulse.
module puf_soc_uart_tx
    import puf_soc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_tx_enable,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_tx_serial,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int unsigned NUM_BYTES  = DATA_WIDTH / UART_BYTE_W;
    localparam int unsigned BYTE_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NUM_BYTES - 1);

    tx_state_e               r_state;
    logic                    r_en_q;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [2:0]              r_bit_idx;
    logic [BYTE_IDX_W-1:0]   r_byte_idx;
    logic                    r_serial;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_tick;
    logic                    w_clear;
    logic                    w_start;
    logic [2:0]              w_next_bit;
    logic [UART_BYTE_W-1:0]  w_cur_byte;

    // Timer idles at zero outside a transfer so every START entry begins a full bit period.
    assign w_clear    = (r_state == TX_IDLE) || (r_state == TX_DONE);
    assign w_start    = (r_state == TX_IDLE) && i_tx_enable && !r_en_q;
    assign w_next_bit = r_bit_idx + 3'd1;
    assign w_cur_byte = r_shift[UART_BYTE_W-1:0];

    puf_soc_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TX_IDLE;
            r_en_q     <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_en_q <= i_tx_enable;
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    if (w_start) begin
                        r_shift    <= i_tx_data;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_serial   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_serial  <= w_cur_byte[0];
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= TX_STOP;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_serial  <= w_cur_byte[w_next_bit];
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_byte_idx < LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
                            r_shift    <= r_shift >> UART_BYTE_W;
                            r_serial   <= 1'b0;
                            r_state    <= TX_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= TX_DONE;
                        end
                    end
                end
                TX_DONE: begin
                    r_serial <= 1'b1;
                    r_state  <= TX_IDLE;
                end
                default: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_tx_serial = r_serial;
    assign o_tx_busy   = r_busy;
    assign o_tx_done   = r_done;

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n) r_done |=> !r_done);
    a_idle_line:   assert property (@(posedge clk) disable iff (!rst_n)
                                    (r_state == TX_IDLE) |-> r_serial);
    a_done_idle:   assert property (@(posedge clk) disable iff (!rst_n) r_done |-> !r_busy);

endmodule

// File: doc/puf_soc_uart_tx.md
Name: puf_soc_uart_tx

Overview:
Serial transmitter for the PUF SoC response path, the TX end of the link whose RX end feeds the controller's i_rx_* handshake.
- The controller drives o_tx_enable (level, held during TRANSMIT) and o_max_count (response word).
- This block frames that word into 8N1 UART bytes on a single serial line.
- It returns a one-cycle done pulse to the controller's i_tx_done.

Parameters:
DATA_WIDTH, 32, response word width (8*$clog2(MUX_LENGTH) for MUX_LENGTH=16); must be a multiple of 8
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2
NUM_BYTES, DATA_WIDTH/8, derived localparam, bytes per frame burst

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_tx_enable  input  1  transmit request level from controller (o_tx_enable)
i_tx_data  input  DATA_WIDTH  response word (controller o_max_count)
o_tx_serial  output  1  UART TX line, idle high
o_tx_busy  output  1  high while a word transfer is in progress
o_tx_done  output  1  one-cycle pulse at end of word; drives controller i_tx_done

Behaviour:
- Single clock; reset asynchronous active-low. Reset values: o_tx_serial=1, o_tx_busy=0, o_tx_done=0, FSM=IDLE, all counters 0.
- Start condition: rising edge of i_tx_enable, using a registered copy en_q (reset 0). A held-high level never retriggers.
- At edge N where i_tx_enable=1 and en_q=0 in IDLE:
  - latch i_tx_data into shift register;
  - byte index=0;
  - go to START.
  - From edge N+1: o_tx_serial=0 and o_tx_busy=1.
- FSM states, encoded in the package enum: IDLE, START, DATA, STOP, DONE.
  - IDLE: line=1. Leaves only on the start condition.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: line=current byte bit[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. If byte index < NUM_BYTES-1: byte index++, go to START. Otherwise go to DONE.
  - DONE: exactly one cycle. o_tx_done=1, o_tx_busy=0, line=1, then IDLE.
- Byte order: least significant byte first.
- Total time from first start-bit cycle to o_tx_done = NUM_BYTES*10*CLKS_PER_BIT cycles. No inter-byte gap.
- Baud counter counts 0..CLKS_PER_BIT-1. A tick is asserted on terminal count; the counter clears on every state entry.
- i_tx_data is sampled only at the start condition. Later changes are ignored until the next word.
- i_tx_enable falling mid-transfer: ignored; the word completes and done still pulses.
- i_tx_enable falls and rises again while busy: ignored. en_q still tracks the input, so no queued request is kept.
- i_tx_enable high in the DONE cycle with en_q high: no restart.
- Reset mid-transfer: line returns to 1 asynchronously, no done pulse, and the partial word is discarded.

Decomposition:
- puf_soc_pkg holds:
  - typedef enum logic [2:0] tx_state_e {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE};
  - localparams UART_FRAME_BITS=10 and UART_BYTE_W=8.
- One sub-module: puf_soc_baud_gen.
  - Inputs: clk, rst_n, clear. Output: tick.
  - Parameter: CLKS_PER_BIT.
  - $clog2(CLKS_PER_BIT)-bit counter.
- The top level holds the FSM, shift register, bit/byte indices and edge detect.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=32):
1. Reset held 5 cycles, then released -> o_tx_serial=1, o_tx_busy=0, o_tx_done=0 throughout; no activity for 20 cycles.
2. i_tx_data=32'h0000_04A5, i_tx_enable 0->1 at edge N and held:
   - line low for 4 cycles from N+1;
   - bits 1,0,1,0,0,1,0,1 (A5 LSB first), then stop;
   - then bytes 04, 00, 00;
   - o_tx_done pulses exactly at cycle N+1+160, and busy drops in that same cycle.
3. After scenario 2, i_tx_enable held high 50 more cycles -> no second start bit; line stays 1.
4. Enable pulsed 1 cycle with i_tx_data=32'hDEAD_BEEF, then i_tx_data changed to 0 -> full word EF,BE,AD,DE still transmitted; done pulses once.
5. Reset asserted during byte 2 data bits -> line=1 and busy=0 immediately, no done pulse. A fresh enable edge with 32'h1234_5678 afterwards transmits 78,56,34,12 correctly.
6. Integration with puf_soc_cntrlr: o_tx_done into i_tx_done -> controller leaves TRANSMIT the cycle after the done pulse; the next enable edge produces a second complete word.
